intensity_palette_pipe: RTL and testbench



---
 rtl/intensity_palette_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_intensity_palette_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/intensity_palette_pipe.sv
// -----------------------------------------------------------------------------
// intensity_palette_pipe
//
// Pixel clock-enable generator and colour/intensity expander for Williams-style
// video. Colour and intensity from the core are captured once per pixel, then
// expanded through a host-loadable LUT (mode 0) or a linear c*i product
// (mode 1). One synchronous LUT read port is time-shared across R, G and B.
// Blank/sync are delayed so they leave together with the colour they belong to.
//
// Ports
//   clk_sys, reset_n             clock, asynchronous active-low reset
//   mode                         0 = LUT, 1 = linear (sampled at capture only)
//   r_in, g_in, b_in, i_in       colour and intensity from the core
//   hblank_in, vblank_in,
//   hs_in, vs_in                 video timing from the core
//   lut_wr, lut_addr, lut_data   host LUT write port, address = {colour, i}
//   ce_pix                       pixel enable to the core, one clk per CE_DIV
//   ce_out                       enable marking fresh output data
//   r_out, g_out, b_out          expanded colour
//   hblank_out, vblank_out,
//   hs_out, vs_out               timing aligned to the expanded colour
//
// Pipeline, relative to capture edge A (the edge where ce_pix = 1):
//   A    hold registers load
//   A+1  LUT address {r,i}
//   A+2  address {g,i}   ; LUT data for r valid
//   A+3  address {b,i}   ; r data parked, LUT data for g valid
//   A+4                  ; g data parked, LUT data for b valid
//   A+5  outputs load, ce_out high in the following cycle
// Requires OW >= CW+IW and CE_DIV >= 6 so pixels never overlap.
// -----------------------------------------------------------------------------
module intensity_palette_pipe #(
  parameter int CW     = 4,
  parameter int IW     = 4,
  parameter int OW     = 8,
  parameter int CE_DIV = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [CW-1:0]    r_in,
  input  logic [CW-1:0]    g_in,
  input  logic [CW-1:0]    b_in,
  input  logic [IW-1:0]    i_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             lut_wr,
  input  logic [CW+IW-1:0] lut_addr,
  input  logic [OW-1:0]    lut_data,
  output logic             ce_pix,
  output logic             ce_out,
  output logic [OW-1:0]    r_out,
  output logic [OW-1:0]    g_out,
  output logic [OW-1:0]    b_out,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             hs_out,
  output logic             vs_out
);

  localparam int AW    = CW + IW;
  localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int SHIFT = OW - AW;

  // Linear expansion: unsigned c*i, left-justified into OW bits.
  function automatic logic [OW-1:0] lin_expand(input logic [CW-1:0] c,
                                               input logic [IW-1:0] i);
    logic [AW-1:0] p;
    p = AW'(c) * AW'(i);
    return OW'(p) << SHIFT;
  endfunction

  // Final channel value; zero intensity is black in both modes.
  function automatic logic [OW-1:0] pix_value(input logic          m,
                                              input logic [IW-1:0] i,
                                              input logic [CW-1:0] c,
                                              input logic [OW-1:0] lut_val);
    if (i == '0)
      return '0;
    else if (m)
      return lin_expand(c, i);
    else
      return lut_val;
  endfunction

  // Divider and phase tracking
  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_pix_q, ce_pix_d;
  logic [4:0]       ph_q, ph_d;        // ph_q[k] set in the cycle after edge A+k

  // Hold registers (loaded at capture)
  logic [CW-1:0]    r_h_q, r_h_d, g_h_q, g_h_d, b_h_q, b_h_d;
  logic [IW-1:0]    i_h_q, i_h_d;
  logic             mode_h_q, mode_h_d;
  logic [3:0]       tim_h_q, tim_h_d;  // {hblank, vblank, hs, vs}

  // LUT read path
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [OW-1:0]    rd_data_q;
  logic [OW-1:0]    r_lut_q, r_lut_d, g_lut_q, g_lut_d;
  logic [OW-1:0]    lut_mem [2**AW];

  // Output registers
  logic [OW-1:0]    r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;
  logic [3:0]       tim_out_q, tim_out_d;
  logic             ce_out_q, ce_out_d;

  always_comb begin
    div_d     = (div_q == DIV_W'(CE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    ce_pix_d  = (div_q == DIV_W'(CE_DIV - 1));
    ph_d      = {ph_q[3:0], ce_pix_q};

    r_h_d     = r_h_q;
    g_h_d     = g_h_q;
    b_h_d     = b_h_q;
    i_h_d     = i_h_q;
    mode_h_d  = mode_h_q;
    tim_h_d   = tim_h_q;
    if (ce_pix_q) begin
      r_h_d    = r_in;
      g_h_d    = g_in;
      b_h_d    = b_in;
      i_h_d    = i_in;
      mode_h_d = mode;
      tim_h_d  = {hblank_in, vblank_in, hs_in, vs_in};
    end

    rd_addr_d = rd_addr_q;
    if (ph_q[0]) rd_addr_d = {r_h_q, i_h_q};
    if (ph_q[1]) rd_addr_d = {g_h_q, i_h_q};
    if (ph_q[2]) rd_addr_d = {b_h_q, i_h_q};

    // Park R and G while the shared read port moves on to the next channel.
    r_lut_d   = ph_q[2] ? rd_data_q : r_lut_q;
    g_lut_d   = ph_q[3] ? rd_data_q : g_lut_q;

    r_out_d   = r_out_q;
    g_out_d   = g_out_q;
    b_out_d   = b_out_q;
    tim_out_d = tim_out_q;
    if (ph_q[4]) begin
      r_out_d   = pix_value(mode_h_q, i_h_q, r_h_q, r_lut_q);
      g_out_d   = pix_value(mode_h_q, i_h_q, g_h_q, g_lut_q);
      b_out_d   = pix_value(mode_h_q, i_h_q, b_h_q, rd_data_q);
      tim_out_d = tim_h_q;
    end
    ce_out_d  = ph_q[4];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      ce_pix_q  <= 1'b0;
      ph_q      <= '0;
      r_h_q     <= '0;
      g_h_q     <= '0;
      b_h_q     <= '0;
      i_h_q     <= '0;
      mode_h_q  <= 1'b0;
      tim_h_q   <= '0;
      rd_addr_q <= '0;
      r_lut_q   <= '0;
      g_lut_q   <= '0;
      r_out_q   <= '0;
      g_out_q   <= '0;
      b_out_q   <= '0;
      tim_out_q <= 4'b1100;  // blanked, syncs inactive
      ce_out_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      ce_pix_q  <= ce_pix_d;
      ph_q      <= ph_d;
      r_h_q     <= r_h_d;
      g_h_q     <= g_h_d;
      b_h_q     <= b_h_d;
      i_h_q     <= i_h_d;
      mode_h_q  <= mode_h_d;
      tim_h_q   <= tim_h_d;
      rd_addr_q <= rd_addr_d;
      r_lut_q   <= r_lut_d;
      g_lut_q   <= g_lut_d;
      r_out_q   <= r_out_d;
      g_out_q   <= g_out_d;
      b_out_q   <= b_out_d;
      tim_out_q <= tim_out_d;
      ce_out_q  <= ce_out_d;
    end
  end

  // Simple dual-port RAM. Contents and its read register are deliberately
  // not reset so it maps onto block RAM; the read register is always
  // refreshed before the pipeline consumes it. A read colliding with a write
  // to the same address returns the old word.
  always_ff @(posedge clk_sys) begin
    if (lut_wr)
      lut_mem[lut_addr] <= lut_data;
    rd_data_q <= lut_mem[rd_addr_q];
  end

  assign ce_pix     = ce_pix_q;
  assign ce_out     = ce_out_q;
  assign r_out      = r_out_q;
  assign g_out      = g_out_q;
  assign b_out      = b_out_q;
  assign hblank_out = tim_out_q[3];
  assign vblank_out = tim_out_q[2];
  assign hs_out     = tim_out_q[1];
  assign vs_out     = tim_out_q[0];

endmodule

// File: tb/tb_intensity_palette_pipe.sv
// -----------------------------------------------------------------------------
// tb_intensity_palette_pipe
//
// Table of pixels (inputs + expected outputs) is driven at ce_pix, expected
// results are queued and popped by a monitor on every ce_out. Inputs churn
// randomly between capture edges. Hand-written sequences cover reset and
// divider start-up, a LUT read/write collision and reset in mid-pixel.
// -----------------------------------------------------------------------------
module tb_intensity_palette_pipe;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       mode;
  logic [3:0] r_in, g_in, b_in, i_in;
  logic       hblank_in, vblank_in, hs_in, vs_in;
  logic       lut_wr;
  logic [7:0] lut_addr;
  logic [7:0] lut_data;
  logic       ce_pix, ce_out;
  logic [7:0] r_out, g_out, b_out;
  logic       hblank_out, vblank_out, hs_out, vs_out;

  intensity_palette_pipe #(.CW(4), .IW(4), .OW(8), .CE_DIV(8)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .mode(mode),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .i_in(i_in),
    .hblank_in(hblank_in), .vblank_in(vblank_in), .hs_in(hs_in), .vs_in(vs_in),
    .lut_wr(lut_wr), .lut_addr(lut_addr), .lut_data(lut_data),
    .ce_pix(ce_pix), .ce_out(ce_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out),
    .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit       mode;
    bit [3:0] r, g, b, i;
    bit [3:0] tim;          // {hblank, vblank, hs, vs}
    bit [7:0] er, eg, eb;
  } vec_t;

  typedef struct {
    bit [7:0] r, g, b;
    bit [3:0] tim;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tim_now();
    return {hblank_out, vblank_out, hs_out, vs_out};
  endfunction

  // Monitor: ce_pix period, ce_out alignment, scoreboard pops, output holding.
  int       cyc = 0;
  int       last_pix = 0;
  bit       have_pix = 0;
  bit [7:0] prev_r, prev_g, prev_b;
  bit [3:0] prev_tim;

  always @(negedge clk_sys) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      have_pix = 0;
      q.delete();
      prev_r = 0; prev_g = 0; prev_b = 0; prev_tim = 4'b1100;
    end else begin
      if (ce_pix) begin
        if (have_pix) chk("ce_pix_period", cyc - last_pix, 8);
        last_pix = cyc;
        have_pix = 1;
      end
      if (ce_out) begin
        // ce_pix cycle precedes capture edge A; ce_out follows edge A+5.
        chk("ce_out_after_ce_pix", have_pix ? cyc - last_pix : -1, 6);
        if (q.size() == 0) begin
          chk("spurious_ce_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("r_out", r_out, e.r);
          chk("g_out", g_out, e.g);
          chk("b_out", b_out, e.b);
          chk("timing_out", tim_now(), e.tim);
        end
        prev_r = r_out; prev_g = g_out; prev_b = b_out; prev_tim = tim_now();
      end else begin
        chk("outputs_hold",
            (r_out == prev_r && g_out == prev_g && b_out == prev_b &&
             tim_now() == int'(prev_tim)) ? 1 : 0, 1);
      end
    end
  end

  // Wait for the next ce_pix (churning inputs meanwhile), then drive vector v.
  task automatic drive_pixel(input vec_t v, input bit push, output int waited);
    exp_t e;
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
      if (!ce_pix) begin
        mode      = 1'($urandom_range(0, 1));
        r_in      = 4'($urandom_range(0, 15));
        g_in      = 4'($urandom_range(0, 15));
        b_in      = 4'($urandom_range(0, 15));
        i_in      = 4'($urandom_range(0, 15));
        hblank_in = ~hblank_in;
        hs_in     = ~hs_in;
        vblank_in = 1'($urandom_range(0, 1));
        vs_in     = 1'($urandom_range(0, 1));
      end
    end while (!ce_pix && waited < 40);
    if (!ce_pix) begin
      chk("ce_pix_timeout", 0, 1);
    end else begin
      mode = v.mode; r_in = v.r; g_in = v.g; b_in = v.b; i_in = v.i;
      {hblank_in, vblank_in, hs_in, vs_in} = v.tim;
      if (push) begin
        e.r = v.er; e.g = v.eg; e.b = v.eb; e.tim = v.tim;
        q.push_back(e);
      end
    end
  endtask

  task automatic lut_load(input bit [7:0] a, input bit [7:0] d);
    @(negedge clk_sys);
    lut_wr = 1'b1; lut_addr = a; lut_data = d;
    @(negedge clk_sys);
    lut_wr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, {r_out, g_out, b_out}, 0);
    chk({tag, "_timing"}, tim_now(), 4'b1100);
    chk({tag, "_ce"}, {ce_pix, ce_out}, 0);
  endtask

  // Called on the negedge reset_n rises: edges 1..7 must not raise ce_pix.
  task automatic check_divider_start();
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk_sys);
      chk($sformatf("ce_pix_early_edge%0d", e), ce_pix, 0);
    end
  endtask

  vec_t vecs[8];
  vec_t v;
  int   waited;

  initial begin
    //            mode  r     g     b     i     tim      er   eg   eb
    vecs[0] = '{1'b0, 4'hF, 4'h3, 4'h3, 4'h1, 4'b0010,  91,  24,  24};
    vecs[1] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1001, 255, 255, 255};
    vecs[2] = '{1'b1, 4'hF, 4'h8, 4'h0, 4'hF, 4'b0111, 225, 120,   0};
    vecs[3] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'b1100,   0,   0,   0};
    vecs[4] = '{1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'b0000,   0,   0,   0};
    vecs[5] = '{1'b0, 4'h5, 4'hA, 4'h0, 4'h7, 4'b0101, 200,  17,   3};
    vecs[6] = '{1'b1, 4'h3, 4'h5, 4'h7, 4'h2, 4'b1010,   6,  10,  14};
    vecs[7] = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 4'b0011,   1,   1,   1};

    reset_n = 1'b0; mode = 1'b0;
    r_in = 0; g_in = 0; b_in = 0; i_in = 0;
    hblank_in = 1'b0; vblank_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    lut_wr = 1'b0; lut_addr = 0; lut_data = 0;

    // LUT loads while in reset: the write port is not affected by reset.
    lut_load(8'hFF, 8'd255);
    lut_load(8'h31, 8'd24);
    lut_load(8'hF1, 8'd91);
    lut_load(8'h57, 8'd200);
    lut_load(8'hA7, 8'd17);
    lut_load(8'h07, 8'd3);
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    check_divider_start();

    for (int k = 0; k < 8; k++) begin
      drive_pixel(vecs[k], 1'b1, waited);
      if (k == 0) chk("first_ce_pix_at_edge8", waited, 1);
    end

    // Collision: write {F,1}=50 on edge A+2 while R reads it; G reads it
    // one edge later and must see the new word.
    v = '{1'b0, 4'hF, 4'hF, 4'h3, 4'h1, 4'b0110, 91, 50, 24};
    drive_pixel(v, 1'b1, waited);
    @(negedge clk_sys);                      // after edge A
    @(negedge clk_sys);                      // after edge A+1
    lut_wr = 1'b1; lut_addr = 8'hF1; lut_data = 8'd50;
    @(negedge clk_sys);                      // after edge A+2
    lut_wr = 1'b0;

    // Reset in mid-pixel: write {3,1}=99 at A+2, assert reset before A+3.
    v = '{1'b0, 4'h3, 4'h3, 4'h3, 4'h1, 4'b0011, 24, 24, 24};
    drive_pixel(v, 1'b0, waited);
    @(negedge clk_sys);
    @(negedge clk_sys);
    lut_wr = 1'b1; lut_addr = 8'h31; lut_data = 8'd99;
    @(negedge clk_sys);
    lut_wr = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    repeat (2) @(negedge clk_sys);
    check_reset_outputs("mid_reset_hold");
    reset_n = 1'b1;
    check_divider_start();

    v = '{1'b0, 4'h3, 4'h3, 4'h3, 4'h1, 4'b0001, 99, 99, 99};
    drive_pixel(v, 1'b1, waited);
    chk("first_ce_pix_after_mid_reset", waited, 1);
    drive_pixel(vecs[2], 1'b1, waited);

    for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk_sys);
    chk("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
